button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Conditions the raw, bouncy push-button input before it reaches the display/control top module.
//  - Synchronises the asynchronous pad signal and filters contact bounce.
//  - Emits a clean level plus single-cycle press/release strobes.
//  - Optional auto-repeat: press strobes are re-issued while the button is held.
//  - Sits between the board button pin and every consumer of "button" in the top module.
// PARAMETERS
//  STABLE_CYCLES  500000  consecutive identical sync samples required to accept a level change (5 ms @100 MHz)
//  HOLD_CYCLES    50000000  cycles held before first auto-repeat strobe (0.5 s)
//  REPEAT_CYCLES  10000000  cycles between subsequent auto-repeat strobes (0.1 s)
//  REPEAT_EN      0         1 = auto-repeat enabled; 0 = one press_pulse per physical press
// PORTS
//  clk            in   1   system clock, 100 MHz
//  reset          in   1   synchronous, active-low reset
//  button         in   1   raw asynchronous button pad, active-high
//  btn_level      out  1   debounced button level
//  press_pulse    out  1   1-cycle strobe on accepted press, and on each auto-repeat
//  release_pulse  out  1   1-cycle strobe on accepted release
//  repeating      out  1   high while auto-repeat strobes are being issued
// BEHAVIOUR
//  Reset (reset==0 at posedge clk): all outputs 0; sync FFs 0; counters 0; FSM in IDLE.
//  Synchroniser: 2 FFs; sync = second stage. Never use raw button elsewhere.
//  FSM states and transitions:
//   IDLE      : sync==1 -> PRESS_WAIT, cnt<=1.
//   PRESS_WAIT: sync==0 -> IDLE, cnt<=0 (bounce rejected).
//               sync==1 && cnt==STABLE_CYCLES-1 -> PRESSED; btn_level<=1; press_pulse<=1.
//               else cnt++.
//   PRESSED   : sync==0 -> RELEASE_WAIT, cnt<=1.
//               else hold_cnt++; repeat logic below.
//   RELEASE_WAIT: sync==1 -> PRESSED, cnt<=0.
//                 While here: hold/repeat counters frozen; no repeat strobes.
//                 sync==0 && cnt==STABLE_CYCLES-1 -> IDLE; btn_level<=0; release_pulse<=1; repeating<=0.
//  Latency: clean raw rise sampled at edge E0 -> press_pulse high for the single cycle after edge E0+STABLE_CYCLES+2.
//           Release latency is identical.
//  Auto-repeat (REPEAT_EN=1, state PRESSED):
//   - hold_cnt reaches HOLD_CYCLES-1 -> press_pulse, repeating<=1, rep_cnt<=0.
//   - Thereafter every REPEAT_CYCLES cycles -> press_pulse.
//   - hold_cnt saturates; it is cleared on entry to PRESSED from PRESS_WAIT.
//   - REPEAT_EN=0: counters may be optimised away; repeating stays 0.
//  Strobes: registered; never high two consecutive cycles except when REPEAT_CYCLES==1. press_pulse and release_pulse are never high together.
//  Counter widths: $clog2 of the largest parameter +1; no wrap-around ever reaches a compare value.
//  Reset mid-press: returns to IDLE.
//   - No release_pulse emitted.
//   - A still-held button is re-qualified through PRESS_WAIT, producing a fresh press_pulse.
//  Glitch shorter than STABLE_CYCLES in any WAIT state: rejected, no strobe, btn_level unchanged.
// STRUCTURE
//  Shared include (debounce_defs.vh):
//   - FSM state localparams IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
//   - Default timing constants, reused by the top module and benches.
//  Sub-module sync_2ff (clk, reset, d, q): generic 2-flop synchroniser, reset value 0.
//  Remainder (FSM, stability counter, hold/repeat counters) is flat in this module.
// TESTING  (bench overrides STABLE_CYCLES=100, HOLD_CYCLES=1000, REPEAT_CYCLES=500; clk period 10 ns)
//  1. Reset held 20 ns, button=0
//     -> all outputs 0 throughout and 2000 ns after release.
//  2. Bounce: 6 toggles @300 ns spacing, then held high 30 us
//     -> exactly one press_pulse, at 1.0 us + 30 ns after the final rising edge; btn_level=1.
//  3. Release with same bounce pattern
//     -> exactly one release_pulse 1.03 us after the final falling edge; btn_level=0.
//  4. 16 press/release cycles as in 2-3
//     -> count press_pulse==16 and release_pulse==16; never both high.
//  5. REPEAT_EN=1, button held 20 us clean
//     -> press_pulse at t0+1.03 us.
//     -> second strobe 10 us later, then every 5 us; repeating=1 from the first repeat strobe.
//  6. reset=0 for one cycle while btn_level=1 and button held
//     -> outputs clear; no release_pulse; new press_pulse ~1.03 us later.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_debouncer_pkg                                                     |
// | Shared FSM encoding and default timing constants for the debouncer.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer_sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_debouncer_sync_2ff                                                |
// | Generic two-flop synchroniser, clears to 0 on reset.                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_debouncer_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] stage_q;
    logic [1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[0], d};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= 2'b00;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[1];

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_debouncer                                                         |
// | Synchronised, debounced push-button with press/release/auto-repeat.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeating
);

    localparam int CNT_W = $clog2(max3(STABLE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic sync;

    button_debouncer_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button),
        .q     (sync)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             fsm_level_q, fsm_level_d;
    logic             fsm_press_q, fsm_press_d;
    logic             fsm_release_q, fsm_release_d;
    logic             fsm_repeating_q, fsm_repeating_d;
    logic             btn_level_q, btn_level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             repeating_q, repeating_d;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hold_cnt_d      = hold_cnt_q;
        rep_cnt_d       = rep_cnt_q;
        fsm_level_d     = fsm_level_q;
        fsm_press_d     = 1'b0;
        fsm_release_d   = 1'b0;
        fsm_repeating_d = fsm_repeating_q;

        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    hold_cnt_d  = '0;
                    rep_cnt_d   = '0;
                    fsm_level_d = 1'b1;
                    fsm_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    // hold_cnt parks at HOLD_LAST; the repeating flag gates the first strobe
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                    if (REPEAT_EN != 0) begin
                        if (!fsm_repeating_q) begin
                            if (hold_cnt_q == HOLD_LAST) begin
                                fsm_press_d     = 1'b1;
                                fsm_repeating_d = 1'b1;
                                rep_cnt_d       = '0;
                            end
                        end else if (rep_cnt_q == REPEAT_LAST) begin
                            fsm_press_d = 1'b1;
                            rep_cnt_d   = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + CNT_ONE;
                        end
                    end
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    fsm_level_d     = 1'b0;
                    fsm_release_d   = 1'b1;
                    fsm_repeating_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Output stage presents FSM decisions one cycle later, all outputs aligned
        btn_level_d     = fsm_level_q;
        press_pulse_d   = fsm_press_q;
        release_pulse_d = fsm_release_q;
        repeating_d     = fsm_repeating_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            hold_cnt_q      <= '0;
            rep_cnt_q       <= '0;
            fsm_level_q     <= 1'b0;
            fsm_press_q     <= 1'b0;
            fsm_release_q   <= 1'b0;
            fsm_repeating_q <= 1'b0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeating_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            rep_cnt_q       <= rep_cnt_d;
            fsm_level_q     <= fsm_level_d;
            fsm_press_q     <= fsm_press_d;
            fsm_release_q   <= fsm_release_d;
            fsm_repeating_q <= fsm_repeating_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            repeating_q     <= repeating_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeating     = repeating_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_debouncer                                                      |
// | Randomised bench with a run-length debounce model and repeat timing.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_button_debouncer;

    localparam int STABLE  = 100;
    localparam int HOLD    = 1000;
    localparam int REPEAT  = 500;
    localparam int LATENCY = 103;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic button = 1'b0;

    logic lvl0, prs0, rel0, rep0;
    logic lvl1, prs1, rel1, rep1;

    int cyc = 0, n_checks = 0, n_pass = 0;
    int n_press = 0, n_rel = 0, last_press = 0, last_rel = 0;
    int p1_q[$];

    always #5 clk = ~clk;

    button_debouncer #(.STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD),
                       .REPEAT_CYCLES(REPEAT), .REPEAT_EN(0)) dut0 (
        .clk(clk), .reset(reset), .button(button),
        .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0), .repeating(rep0));

    button_debouncer #(.STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD),
                       .REPEAT_CYCLES(REPEAT), .REPEAT_EN(1)) dut1 (
        .clk(clk), .reset(reset), .button(button),
        .btn_level(lvl1), .press_pulse(prs1), .release_pulse(rel1), .repeating(rep1));

    // Reference: accepted level flips after STABLE consecutive differing synced samples;
    // outputs become visible one cycle after acceptance.
    logic m_s1 = 0, m_s2 = 0, m_level = 0, m_press = 0, m_rel = 0;
    logic exp_level = 0, exp_press = 0, exp_rel = 0;
    int   m_run = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_s1 <= 0; m_s2 <= 0; m_level <= 0; m_press <= 0; m_rel <= 0; m_run <= 0;
            exp_level <= 0; exp_press <= 0; exp_rel <= 0;
        end else begin
            m_s1 <= button;
            m_s2 <= m_s1;
            exp_level <= m_level;
            exp_press <= m_press;
            exp_rel   <= m_rel;
            m_press <= 0;
            m_rel   <= 0;
            if (m_s2 != m_level) begin
                if (m_run + 1 == STABLE) begin
                    m_level <= m_s2;
                    m_press <= m_s2;
                    m_rel   <= !m_s2;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if ({lvl0, prs0, rel0, rep0} !== {exp_level, exp_press, exp_rel, 1'b0}) begin
                $display("FAIL model_cmp cyc=%0d lvl/prs/rel/rep got %b expected %b",
                         cyc, {lvl0, prs0, rel0, rep0}, {exp_level, exp_press, exp_rel, 1'b0});
            end else n_pass++;
            n_checks++;
            if (((prs0 & rel0) | (prs1 & rel1)) !== 1'b0) begin
                $display("FAIL both_strobes cyc=%0d got dut0=%b%b dut1=%b%b expected never both",
                         cyc, prs0, rel0, prs1, rel1);
            end else n_pass++;
            if (prs0 === 1'b1) begin n_press++; last_press = cyc; end
            if (rel0 === 1'b1) begin n_rel++;   last_rel   = cyc; end
            if (prs1 === 1'b1) p1_q.push_back(cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; button = 1'b0;
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(1);
            n_checks++;
            if ({lvl0, prs0, rel0, rep0, lvl1, prs1, rel1, rep1} !== 8'h00) begin
                $display("FAIL reset_idle cyc=%0d got %b expected 00000000", cyc,
                         {lvl0, prs0, rel0, rep0, lvl1, prs1, rel1, rep1});
            end else n_pass++;
        end
    endtask

    task automatic test_bounce_press();
        int p0, r;
        p0 = n_press;
        for (int k = 0; k < 3; k++) begin
            button = 1'b1; step(30);
            button = 1'b0; step(30);
        end
        button = 1'b1; r = cyc;
        step(3000);
        n_checks++;
        if (n_press - p0 !== 1) $display("FAIL press_count got %0d expected 1", n_press - p0);
        else n_pass++;
        n_checks++;
        if ((last_press - r) * 10 !== LATENCY * 10)
            $display("FAIL press_latency got %0d ns expected %0d ns", (last_press - r) * 10, LATENCY * 10);
        else n_pass++;
        n_checks++;
        if (lvl0 !== 1'b1) $display("FAIL press_level got %b expected 1", lvl0);
        else n_pass++;
    endtask

    task automatic test_bounce_release();
        int r0, r;
        r0 = n_rel;
        for (int k = 0; k < 3; k++) begin
            button = 1'b0; step(30);
            button = 1'b1; step(30);
        end
        button = 1'b0; r = cyc;
        step(400);
        n_checks++;
        if (n_rel - r0 !== 1) $display("FAIL release_count got %0d expected 1", n_rel - r0);
        else n_pass++;
        n_checks++;
        if ((last_rel - r) * 10 !== LATENCY * 10)
            $display("FAIL release_latency got %0d ns expected %0d ns", (last_rel - r) * 10, LATENCY * 10);
        else n_pass++;
        n_checks++;
        if (lvl0 !== 1'b0) $display("FAIL release_level got %b expected 0", lvl0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int p0, r0, nb;
        p0 = n_press; r0 = n_rel;
        for (int c = 0; c < 16; c++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                button = 1'b1; step($urandom_range(1, 60));
                button = 1'b0; step($urandom_range(1, 60));
            end
            button = 1'b1; step($urandom_range(150, 400));
            for (int b = 0; b < nb; b++) begin
                button = 1'b0; step($urandom_range(1, 60));
                button = 1'b1; step($urandom_range(1, 60));
            end
            button = 1'b0; step($urandom_range(150, 400));
        end
        n_checks++;
        if (n_press - p0 !== 16) $display("FAIL b2b_press_count got %0d expected 16", n_press - p0);
        else n_pass++;
        n_checks++;
        if (n_rel - r0 !== 16) $display("FAIL b2b_release_count got %0d expected 16", n_rel - r0);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            button = 1'($urandom_range(0, 1));
            step($urandom_range(1, 250));
        end
        button = 1'b0;
        step(300);
    endtask

    task automatic test_auto_repeat();
        int r;
        reset = 1'b0; step(1);
        reset = 1'b1; step(5);
        p1_q.delete();
        button = 1'b1; r = cyc;
        step(LATENCY + HOLD - 1);
        n_checks++;
        if (rep1 !== 1'b0) $display("FAIL repeating_early got %b expected 0", rep1);
        else n_pass++;
        step(1);
        n_checks++;
        if (rep1 !== 1'b1) $display("FAIL repeating_set got %b expected 1", rep1);
        else n_pass++;
        step(2000 - LATENCY - HOLD);
        n_checks++;
        if (p1_q.size() !== 3) $display("FAIL repeat_count got %0d expected 3", p1_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < p1_q.size(); i++) begin
            int want;
            want = r + LATENCY + ((i == 0) ? 0 : HOLD + (i - 1) * REPEAT);
            n_checks++;
            if (p1_q[i] !== want) $display("FAIL repeat_time[%0d] got cyc %0d expected cyc %0d", i, p1_q[i], want);
            else n_pass++;
        end
        button = 1'b0;
        step(300);
        n_checks++;
        if ({lvl1, rep1} !== 2'b00) $display("FAIL repeat_release got %b expected 00", {lvl1, rep1});
        else n_pass++;
    endtask

    task automatic test_reset_mid_press();
        int p0, r0, r;
        button = 1'b1;
        step(300);
        n_checks++;
        if ({lvl0, lvl1} !== 2'b11) $display("FAIL midpress_level got %b expected 11", {lvl0, lvl1});
        else n_pass++;
        p0 = n_press; r0 = n_rel;
        reset = 1'b0; step(1);
        n_checks++;
        if ({lvl0, prs0, rel0, rep0, lvl1, prs1, rel1, rep1} !== 8'h00)
            $display("FAIL midpress_clear got %b expected 00000000",
                     {lvl0, prs0, rel0, rep0, lvl1, prs1, rel1, rep1});
        else n_pass++;
        reset = 1'b1; r = cyc;
        step(300);
        n_checks++;
        if (n_rel - r0 !== 0) $display("FAIL midpress_no_release got %0d expected 0", n_rel - r0);
        else n_pass++;
        n_checks++;
        if (n_press - p0 !== 1) $display("FAIL midpress_repress got %0d expected 1", n_press - p0);
        else n_pass++;
        n_checks++;
        if (last_press - r !== LATENCY)
            $display("FAIL midpress_latency got %0d cycles expected %0d", last_press - r, LATENCY);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bounce_press();
        test_bounce_release();
        test_back_to_back();
        test_random();
        test_auto_repeat();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
